cp0_reg: RTL and testbench
==========================

// Module: cp0_reg
// PURPOSE
// - MIPS32 coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// - Consumes the CP0 write triple (we/waddr/wdata) that travels ex -> ex_mem -> mem -> mem_wb; write lands at WB.
// - Serves combinational reads to the EX stage (mtc0/mfc0 hazard bypass lives in EX, not here).
// - Takes exception/eret requests from the MEM stage; drives the timer interrupt.
// PARAMETERS
// - PRID_VAL    32'h004c_0102  read-only PRId value
// - CONFIG_RST  32'h0000_8000  Config reset value (BE=1, MIPS32); read-only
// - STATUS_RST  32'h1000_0000  Status reset value (CU0=1, EXL=0, IE=0)
// PORTS
// - clk                 in   1   rising-edge clock
// - rst                 in   1   asynchronous reset, active-low
// - we_i                in   1   CP0 write enable (from mem_wb)
// - waddr_i             in   5   CP0 write register number
// - wdata_i             in   32  CP0 write data
// - raddr_i             in   5   CP0 read register number (from EX)
// - int_i               in   6   hardware interrupt lines, sampled into Cause.IP[7:2]
// - excepttype_i        in   32  exception code from MEM; 0 = none
// - current_inst_addr_i in   32  PC of the excepting instruction
// - is_in_delayslot_i   in   1   excepting instruction sits in a branch delay slot
// - data_o              out  32  read data for raddr_i (combinational)
// - count_o/compare_o/status_o/cause_o/epc_o/config_o/prid_o  out 32 each  register images
// - timer_int_o         out  1   timer interrupt, level, sticky until Compare written
// BEHAVIOUR
// - Reset (rst=0, async): count=0, compare=0, status=STATUS_RST, cause=0, epc=0,
//   config=CONFIG_RST, prid=PRID_VAL, timer_int_o=0. data_o follows raddr_i combinationally.
// - Addresses: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16; others read 0.
// - Count: +1 every cycle, wraps 32'hFFFF_FFFF->0. Write to Count loads wdata_i (no increment that cycle).
// - Timer: compare!=0 && count==compare (registered values) -> timer_int_o<=1 next edge.
//   Write to Compare loads wdata_i and clears timer_int_o; clear wins over a same-cycle match.
// - Status: all 32 bits writable. Compare: all bits. EPC: all bits.
// - Cause: writable bits only IP[1:0]=[9:8], WP=[22], IV=[23]; rest ignore writes.
//   Cause[15:10] <= int_i every cycle, unconditionally.
// - Read latency 0: data_o reflects registers as of the last edge; a same-cycle write is NOT forwarded.
// - Exception entry (excepttype_i != 0), evaluated after the software write in the same cycle;
//   exception updates override write data for the fields they touch:
//   * 32'h1 interrupt: EPC=addr-4 & Cause.BD=1 if delayslot else EPC=addr & BD=0; EXL=1; ExcCode=0.
//   * 32'h8 syscall(8), 32'ha RI(10), 32'hc Ov(12), 32'hd trap(13): if EXL==0 update EPC/BD as above,
//     else EPC/BD unchanged; EXL=1; ExcCode=code.
//   * 32'he eret: Status.EXL=0; nothing else.
//   * any other nonzero code: no state change.
// - ExcCode is Cause[6:2]; BD is Cause[31]; EXL is Status[1]; IE is Status[0].
// - Count increments in exception cycles too. Reset mid-operation discards everything, incl. pending timer_int.
// STRUCTURE
// - defines.v gains: CP0_REG_COUNT/COMPARE/STATUS/CAUSE/EPC/PRID/CONFIG (5-bit);
//   EXC_INT/SYSCALL/RI/OV/TRAP/ERET (32-bit); Status/Cause bit-position constants.
// - Single flat module; no sub-module (timer is a few lines, splitting adds ports only).
// TESTING
// - Reset release: read addrs 9,11,12,13,14,15,16 -> 0,0,1000_0000,0,0,004c_0102,0000_8000; count=5 after 5 edges.
// - Write Compare=0x20 with Count=0x10 -> timer_int_o=1 exactly one edge after count==0x20;
//   stays 1 until Compare rewritten (0x40) -> 0 next edge.
// - Write Cause=0xFFFF_FFFF, int_i=6'b101010 -> cause reads 0x00C0_A B00 pattern = 0x00C0_AB00.
// - Syscall at addr 0x100 in delay slot -> EPC=0xFC, BD=1, EXL=1, ExcCode=8;
//   second syscall at 0x200 while EXL=1 -> EPC stays 0xFC; eret -> EXL=0.
// - Same-cycle mtc0 EPC=0x1234 with interrupt at 0x300 (not delay slot) -> EPC=0x300.
// - Count write 0xFFFF_FFFE -> reads 0xFFFF_FFFF, then 0 (wrap); assert rst mid-run -> all outputs reset immediately.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
// CP0 register numbers, exception codes and field positions.
// Shared by the cp0 register file and the pipeline stages.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_RI      = 32'ha;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_ERET    = 32'he;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_IV   = 23;
  localparam int CAUSE_WP   = 22;
  localparam int CAUSE_IP_H = 15;
  localparam int CAUSE_IP_L = 10;
  localparam int CAUSE_SW_H = 9;
  localparam int CAUSE_SW_L = 8;
  localparam int CAUSE_EC_H = 6;
  localparam int CAUSE_EC_L = 2;

endpackage

// File: rtl/cp0_reg.sv
// MIPS32 CP0 register file with Count/Compare timer.
// Writes land at WB; exceptions from MEM override write data.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_RST = 32'h0000_8000,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] count, compare, status, cause, epc;
  logic [31:0] count_n, compare_n, status_n, cause_n, epc_n;
  logic        timer, timer_n;
  logic [31:0] exc_epc;
  logic        exc_bd;

  assign exc_epc = is_in_delayslot_i
                 ? current_inst_addr_i - 32'd4
                 : current_inst_addr_i;
  assign exc_bd  = is_in_delayslot_i;

  always_comb begin
    count_n   = count + 32'd1;
    compare_n = compare;
    status_n  = status;
    cause_n   = cause;
    epc_n     = epc;
    timer_n   = timer;

    cause_n[CAUSE_IP_H:CAUSE_IP_L] = int_i;
    if (compare != 32'd0 && count == compare)
      timer_n = 1'b1;

    if (we_i) begin
      case (waddr_i)
        CP0_REG_COUNT:   count_n = wdata_i;
        CP0_REG_COMPARE: begin
          compare_n = wdata_i;
          timer_n   = 1'b0;
        end
        CP0_REG_STATUS:  status_n = wdata_i;
        CP0_REG_EPC:     epc_n = wdata_i;
        CP0_REG_CAUSE: begin
          cause_n[CAUSE_SW_H:CAUSE_SW_L] =
            wdata_i[CAUSE_SW_H:CAUSE_SW_L];
          cause_n[CAUSE_WP] = wdata_i[CAUSE_WP];
          cause_n[CAUSE_IV] = wdata_i[CAUSE_IV];
        end
        default: ;
      endcase
    end

    // Exception entry sees the post-write state and wins on shared fields.
    case (excepttype_i)
      EXC_INT: begin
        epc_n                          = exc_epc;
        cause_n[CAUSE_BD]              = exc_bd;
        status_n[STATUS_EXL]           = 1'b1;
        cause_n[CAUSE_EC_H:CAUSE_EC_L] = 5'd0;
      end
      EXC_SYSCALL, EXC_RI, EXC_OV, EXC_TRAP: begin
        if (!status_n[STATUS_EXL]) begin
          epc_n             = exc_epc;
          cause_n[CAUSE_BD] = exc_bd;
        end
        status_n[STATUS_EXL]           = 1'b1;
        cause_n[CAUSE_EC_H:CAUSE_EC_L] = excepttype_i[4:0];
      end
      EXC_ERET: status_n[STATUS_EXL] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= 32'd0;
      compare <= 32'd0;
      status  <= STATUS_RST;
      cause   <= 32'd0;
      epc     <= 32'd0;
      timer   <= 1'b0;
    end else begin
      count   <= count_n;
      compare <= compare_n;
      status  <= status_n;
      cause   <= cause_n;
      epc     <= epc_n;
      timer   <= timer_n;
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      CP0_REG_COUNT:   data_o = count;
      CP0_REG_COMPARE: data_o = compare;
      CP0_REG_STATUS:  data_o = status;
      CP0_REG_CAUSE:   data_o = cause;
      CP0_REG_EPC:     data_o = epc;
      CP0_REG_PRID:    data_o = PRID_VAL;
      CP0_REG_CONFIG:  data_o = CONFIG_RST;
      default:         data_o = 32'd0;
    endcase
  end

  assign count_o     = count;
  assign compare_o   = compare;
  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign config_o    = CONFIG_RST;
  assign prid_o      = PRID_VAL;
  assign timer_int_o = timer;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: reset, timer, cause mask,
// exception entry/eret, count wrap and async reset.
module tb_cp0_reg;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o;
  logic [31:0] count_o, compare_o, status_o, cause_o;
  logic [31:0] epc_o, config_o, prid_o;
  logic        timer_int_o;

  int checks = 0;
  int errors = 0;

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .wdata_i             (wdata_i),
    .raddr_i             (raddr_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i                = 1'b0;
    waddr_i             = 5'd0;
    wdata_i             = 32'd0;
    excepttype_i        = 32'd0;
    current_inst_addr_i = 32'd0;
    is_in_delayslot_i   = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    idle();
  endtask

  task automatic exc(input logic [31:0] t,
                     input logic [31:0] pc,
                     input logic ds);
    excepttype_i = t; current_inst_addr_i = pc;
    is_in_delayslot_i = ds;
    tick();
    idle();
  endtask

  task automatic rd(input string tag,
                    input logic [4:0] a,
                    input logic [31:0] exp);
    raddr_i = a;
    #1;
    check(tag, data_o, exp);
  endtask

  logic [4:0]  ra [8];
  logic [31:0] rv [8];
  bit hit;

  initial begin
    rst = 1'b0;
    raddr_i = 5'd0;
    int_i = 6'd0;
    idle();
    ra = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    rv = '{32'h0, 32'h0, 32'h1000_0000, 32'h0, 32'h0,
           32'h004c_0102, 32'h0000_8000, 32'h0};
    repeat (2) tick();

    for (int i = 0; i < 8; i++)
      rd($sformatf("rst_rd%0d", ra[i]), ra[i], rv[i]);

    rst = 1'b1;
    repeat (5) tick();
    check("count5", count_o, 32'd5);

    // Timer
    wr(5'd11, 32'h20);
    wr(5'd9, 32'h10);
    check("count_ld", count_o, 32'h10);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (count_o == 32'h20) hit = 1'b1;
      else tick();
    end
    check("cnt_reach", {31'd0, hit}, 32'd1);
    check("tmr_pre", {31'd0, timer_int_o}, 32'd0);
    tick();
    check("tmr_set", {31'd0, timer_int_o}, 32'd1);
    repeat (4) tick();
    check("tmr_stky", {31'd0, timer_int_o}, 32'd1);
    wr(5'd11, 32'h40);
    check("tmr_clr", {31'd0, timer_int_o}, 32'd0);
    check("cmp_rd", compare_o, 32'h40);

    // Cause write mask and IP sampling
    int_i = 6'b101010;
    wr(5'd13, 32'hFFFF_FFFF);
    rd("cause_msk", 5'd13, 32'h00C0_AB00);
    int_i = 6'd0;
    tick();
    check("cause_ip0", cause_o, 32'h00C0_0300);

    // Syscall in delay slot, nested syscall, eret
    exc(32'h8, 32'h100, 1'b1);
    check("sc_epc", epc_o, 32'hFC);
    check("sc_bd", {31'd0, cause_o[31]}, 32'd1);
    check("sc_exl", {31'd0, status_o[1]}, 32'd1);
    check("sc_code", {27'd0, cause_o[6:2]}, 32'd8);
    exc(32'h8, 32'h200, 1'b0);
    check("sc2_epc", epc_o, 32'hFC);
    check("sc2_bd", {31'd0, cause_o[31]}, 32'd1);
    exc(32'he, 32'h0, 1'b0);
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);
    check("eret_epc", epc_o, 32'hFC);

    // Interrupt overrides same-cycle mtc0 EPC
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h1234;
    exc(32'h1, 32'h300, 1'b0);
    check("int_epc", epc_o, 32'h300);
    check("int_bd", {31'd0, cause_o[31]}, 32'd0);
    check("int_code", {27'd0, cause_o[6:2]}, 32'd0);
    check("int_exl", {31'd0, status_o[1]}, 32'd1);

    // Unknown code leaves state alone
    exc(32'h5, 32'h400, 1'b1);
    check("unk_epc", epc_o, 32'h300);

    // Count wrap
    wr(5'd9, 32'hFFFF_FFFE);
    rd("wrap0", 5'd9, 32'hFFFF_FFFE);
    tick();
    rd("wrap1", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd("wrap2", 5'd9, 32'h0);

    // Re-arm timer against compare 0x40, then async reset
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (timer_int_o) hit = 1'b1;
      else tick();
    end
    check("tmr_rearm", {31'd0, hit}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_tmr", {31'd0, timer_int_o}, 32'd0);
    check("ar_cnt", count_o, 32'd0);
    check("ar_cmp", compare_o, 32'd0);
    check("ar_st", status_o, 32'h1000_0000);
    check("ar_cause", cause_o, 32'd0);
    check("ar_epc", epc_o, 32'd0);
    check("ar_cfg", config_o, 32'h0000_8000);
    check("ar_prid", prid_o, 32'h004c_0102);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
